// File: rtl/hilo_unit.sv
// HI/LO accumulator with mult/madd/mthi/mtlo and an optional iterative divider.
// Define HILO_DIV_EN to build the divider; otherwise div/divu complete as one-cycle no-ops.
module hilo_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [2*XLEN-1:0] mult_res,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic [2*XLEN-1:0] hi_lo,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MADD  = 3'b001,
        OP_MADDU = 3'b010,
        OP_MTHI  = 3'b011,
        OP_MTLO  = 3'b100,
        OP_DIV   = 3'b101,
        OP_DIVU  = 3'b110,
        OP_NOP   = 3'b111
    } op_t;

    op_t             op;
    logic            accept;
    logic            div_start;
    logic            div_zero;
    logic            div_fin;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;

    assign op       = op_t'(op_code);
    assign accept   = op_valid && op_ready;
    assign op_ready = !busy;
    assign hi_lo    = {hi, lo};

`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_FIX
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] dvsr;
    logic            q_neg;
    logic            r_neg;
    logic            is_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign div_start = accept && is_div && (rt_val != '0);
    assign div_zero  = accept && is_div && (rt_val == '0);
    assign busy      = (state != IDLE);
    assign a_neg     = (op == OP_DIV) && rs_val[XLEN-1];
    assign b_neg     = (op == OP_DIV) && rt_val[XLEN-1];

    // quot doubles as the dividend shift register; its MSB feeds the partial remainder
    assign rem_sh = {rem, quot[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr};
    assign div_q  = q_neg ? -quot : quot;
    assign div_r  = r_neg ? -rem  : rem;

    always_comb begin
        state_nxt = state;
        div_fin   = 1'b0;
        case (state)
            IDLE:    if (div_start) state_nxt = DIV_RUN;
            DIV_RUN: if (cnt == '0) state_nxt = DIV_FIX;
            DIV_FIX: begin
                state_nxt = IDLE;
                div_fin   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quot  <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (div_start) begin
                quot  <= a_neg ? -rs_val : rs_val;
                dvsr  <= b_neg ? -rt_val : rt_val;
                rem   <= '0;
                cnt   <= 5'd31;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
            end else if (state == DIV_RUN) begin
                if (!diff[XLEN]) begin
                    rem  <= diff[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b1};
                end else begin
                    rem  <= rem_sh[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b0};
                end
                cnt <= (cnt == '0) ? '0 : cnt - 5'd1;
            end
        end
    end
`else
    logic unused_rt;

    assign unused_rt = ^rt_val;
    assign busy      = 1'b0;
    assign div_start = 1'b0;
    assign div_zero  = 1'b0;
    assign div_fin   = 1'b0;
    assign div_q     = '0;
    assign div_r     = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (accept && !div_start) || div_fin;
            div_by_zero <= div_zero;
            if (div_fin) begin
                hi <= div_r;
                lo <= div_q;
            end else if (accept) begin
                case (op)
                    OP_MULT:           {hi, lo} <= mult_res;
                    OP_MADD, OP_MADDU: {hi, lo} <= {hi, lo} + mult_res;
                    OP_MTHI:           hi <= rs_val;
                    OP_MTLO:           lo <= rs_val;
                    default:           ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_hilo_unit;

    localparam int unsigned XLEN = 32;
`ifdef HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'b111;
    logic [63:0] mult_res = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        op_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hi_lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hilo_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .mult_res   (mult_res),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .hi         (hi),
        .lo         (lo),
        .hi_lo      (hi_lo),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: returns {remainder, quotient} using 64-bit arithmetic.
    function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        la = sgn ? longint'($signed(a)) : longint'(a);
        lb = sgn ? longint'($signed(b)) : longint'(b);
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_dbz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (op_valid) begin
                m_done = 1'b1;
                case (op_code)
                    3'd0: {m_hi, m_lo} = mult_res;
                    3'd1, 3'd2: {m_hi, m_lo} = {m_hi, m_lo} + mult_res;
                    3'd3: m_hi = rs_val;
                    3'd4: m_lo = rs_val;
`ifdef HILO_DIV_EN
                    3'd5, 3'd6: begin
                        if (rt_val == 32'd0) m_dbz = 1'b1;
                        else begin
                            m_pend = div_ref(op_code == 3'd5, rs_val, rt_val);
                            m_left = 33;
                            m_done = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi_lo", hi_lo, {m_hi, m_lo});
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("op_ready", 64'(op_ready), 64'(m_left == 0));
            chk("done", 64'(done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] c, input logic [63:0] mr, input logic [31:0] a,
                         input logic [31:0] b, output int waits);
        op_valid = 1'b1; op_code = c; mult_res = mr; rs_val = a; rt_val = b;
        waits = 0;
        while (!op_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'b111;
        mult_res = {$urandom, $urandom}; rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        bit prev_ready;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_hi_lo", hi_lo, 64'h0);
        chk("rst_ready", 64'(op_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(3'd0, 64'h00000001_FFFFFFFF, 0, 0, w);
        chk("mult", hi_lo, 64'h00000001_FFFFFFFF);
        chk("mult_done", 64'(done), 64'd1);
        issue(3'd1, 64'h1, 0, 0, w);
        chk("madd", hi_lo, 64'h00000002_00000000);
        chk("madd_done", 64'(done), 64'd1);

        issue(3'd3, 0, 32'hDEADBEEF, 0, w);
        issue(3'd4, 0, 32'h12345678, 0, w);
        chk("mthi", 64'(hi), 64'hDEADBEEF);
        chk("mtlo", 64'(lo), 64'h12345678);

        issue(3'd5, 0, 32'hFFFFFFF9, 32'd2, w);
        wait_busy(n);
        chk("div_busy_cycles", 64'(n), DIV_EN ? 64'd33 : 64'd0);
        chk("div_neg7_2", hi_lo, DIV_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'hDEADBEEF_12345678);
        chk("div_done", 64'(done), 64'd1);

        issue(3'd6, 0, 32'hFFFFFFFF, 32'h10, w);
        wait_busy(n);
        chk("divu", hi_lo, DIV_EN ? 64'h0000000F_0FFFFFFF : 64'hDEADBEEF_12345678);

        issue(3'd5, 0, 32'h80000000, 32'hFFFFFFFF, w);
        wait_busy(n);
        chk("div_ovf", hi_lo, DIV_EN ? 64'h00000000_80000000 : 64'hDEADBEEF_12345678);

        issue(3'd3, 0, 32'hAA, 0, w);
        issue(3'd4, 0, 32'hBB, 0, w);
        issue(3'd5, 0, 32'd5, 32'd0, w);
        chk("dbz_flag", 64'(div_by_zero), DIV_EN ? 64'd1 : 64'd0);
        chk("dbz_done", 64'(done), 64'd1);
        chk("dbz_busy", 64'(busy), 64'd0);
        chk("dbz_hilo", hi_lo, 64'h000000AA_000000BB);

        issue(3'd6, 0, 32'd100, 32'd7, w);
        issue(3'd3, 0, 32'h55, 0, w);
        chk("held_waits", 64'(w), DIV_EN ? 64'd33 : 64'd0);
        chk("held_result", hi_lo, DIV_EN ? 64'h00000055_0000000E : 64'h00000055_000000BB);

        issue(3'd5, 0, 32'd1000, 32'd3, w);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_hilo", hi_lo, 64'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end

        prev_ready = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if (!(op_valid && !prev_ready)) begin
                op_valid = ($urandom_range(0, 3) != 0);
                op_code  = 3'($urandom_range(0, 7));
                mult_res = {$urandom, $urandom};
                rs_val   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
                if ($urandom_range(0, 7) == 0) rt_val = 32'd0;
                else if ($urandom_range(0, 1) == 1) rt_val = $urandom;
                else rt_val = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20))
                                                          : -32'($urandom_range(1, 20));
            end
            prev_ready = op_ready;
            @(negedge clk);
        end
        op_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO accumulator and iterative divider sitting directly downstream of the ALU. It takes the ALU's 64-bit `mult_res` and writes it into the architectural HI/LO pair, accumulating it for madd/maddu. It also executes mthi/mtlo and multi-cycle signed/unsigned division. Its `hi_lo` output feeds back into the ALU's `mult_in`.

## Interface
- `XLEN`, 32, operand width; HI/LO are XLEN each, `hi_lo` is 2*XLEN.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request present.
- `op_ready`  out  1  unit can accept; equals !busy.
- `op_code`  in  3  000 mult, 001 madd, 010 maddu, 011 mthi, 100 mtlo, 101 div, 110 divu, 111 no-op.
- `mult_res`  in  2*XLEN  product from the ALU.
- `rs_val`  in  XLEN  dividend; mthi/mtlo source.
- `rt_val`  in  XLEN  divisor.
- `hi`, `lo`  out  XLEN each  registered HI and LO.
- `hi_lo`  out  2*XLEN  {hi, lo}; goes to ALU `mult_in`.
- `busy`  out  1  divide in progress.
- `done`  out  1  one-cycle pulse on completion of any accepted op.
- `div_by_zero`  out  1  one-cycle pulse alongside `done` for div/divu with `rt_val`==0.

## Operation
- Accept: `op_valid && op_ready` at a rising edge (edge E0). All inputs are sampled only at E0, and later changes are ignored. When `op_ready` is low, the request is not taken, and the requester holds `op_valid` and its data.
- mult: `{hi,lo}` <= `mult_res` at E0.
- madd/maddu: `{hi,lo}` <= `{hi,lo}` + `mult_res` at E0.
  - 64-bit modular add; carry-out discarded.
  - Both codes perform the identical add; signedness is the ALU's concern.
- mthi: `hi` <= `rs_val` at E0, `lo` unchanged.
- mtlo: `lo` <= `rs_val` at E0, `hi` unchanged.
- no-op (111): no state change; `done` still pulses.
- div/divu: FSM states IDLE, DIV_RUN, DIV_FIX.
  - Nonzero divisor: IDLE->DIV_RUN at E0. The unit latches the operands; for div it stores magnitudes and the result signs.
  - DIV_RUN: radix-2 restoring division on the magnitudes, one quotient bit per edge. A 5-bit counter runs 31 down to 0, E1..E32. After E32 the state goes to DIV_FIX.
  - DIV_FIX (edge E33): applies signs, writes `lo`=quotient and `hi`=remainder, and returns to IDLE.
  - div sign rules: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - Divisor==0: the unit stays in IDLE, leaves HI/LO unchanged, and pulses `div_by_zero` and `done` after E0.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0. This falls out of the magnitude path and needs no special handling.

## Timing
- Reset values, asserted asynchronously: `hi`=0, `lo`=0, `busy`=0, `op_ready`=1, `done`=0, `div_by_zero`=0, FSM=IDLE, counter=0.
- Single-cycle ops: HI/LO and `hi_lo` show the new value after E0, and `done` is high for the cycle after E0. Back-to-back accepts every cycle are legal, and each madd sees the previous op's result.
- div/divu: `busy` is high from after E0 through E33; it drops and `done` pulses after E33. Latency is 33 edges from accept, and the next op can be accepted at E34.
- HI/LO hold their old values during DIV_RUN; `hi_lo` never exposes partial results.
- Reset mid-divide aborts immediately to the reset values. No `done` is produced.
- `done` and `div_by_zero` are registered, never combinational from inputs.

## Configuration
- `HILO_DIV_EN` defined: the divider FSM, counter and datapath are compiled in, as described above.
- `HILO_DIV_EN` undefined: no divider logic is present.
  - div/divu behave as no-op: accepted in one cycle, HI/LO unchanged, `done` pulses, `div_by_zero` never asserts.
  - `busy` is tied 0 and `op_ready` is tied 1.

## Test plan
- Reset: hold `rst`=0 mid-operation, then release → all outputs at their reset values, `op_ready`=1.
- mult then madd: `mult_res`=0x00000001_FFFFFFFF, then madd with 0x00000000_00000001 → `hi_lo`=0x00000002_00000000 one cycle after each accept, and `done` pulses twice.
- mthi/mtlo: mthi with `rs_val`=0xDEADBEEF, then mtlo with 0x12345678 → `hi`=0xDEADBEEF, `lo`=0x12345678.
- Signed divide: div -7 / 2 → after 33 edges `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF. Checks along the way:
  - `busy` is high for exactly 33 cycles.
  - `op_valid` held during the divide is not accepted until E34.
- divu 0xFFFFFFFF / 0x10 → `lo`=0x0FFFFFFF, `hi`=0xF. Also div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: div 5 / 0 with HI/LO preset to 0xAA/0xBB → HI/LO unchanged, `div_by_zero` and `done` pulse one cycle after accept, `busy` stays 0. Also assert `rst` at E10 of a divide → no `done`, HI/LO=0.
